// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared state encoding, default sizes and clog2 for the approximate multiplier
package approx_mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam int KEEP_DEF = 8;
  localparam int W_DEF = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/approx_lod.sv
// approx_lod: leading-one detect and LSB-side truncation of an operand to KEEP significant bits
module approx_lod
  import approx_mul_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int KEEP = KEEP_DEF,
  parameter int SHW = clog2(W + 1)
) (
  input  logic [W-1:0]    op_i,
  output logic [SHW-1:0]  sh_o,
  output logic [KEEP-1:0] mant_o
);
  logic [SHW-1:0] p;
  logic [W-1:0] shifted;
  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) if (op_i[i]) p = SHW'(i + 1);
    sh_o = (p > SHW'(KEEP)) ? p - SHW'(KEEP) : '0;
    shifted = op_i >> sh_o;
    mant_o = shifted[KEEP-1:0];
  end
endmodule

// File: rtl/approx_mul_sched.sv
// approx_mul_sched: round-robin shared sequential approximate multiplier with tagged results
module approx_mul_sched
  import approx_mul_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int KEEP = KEEP_DEF,
  parameter int W = W_DEF,
  parameter int IDW = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*W-1:0]     res_data,
  output logic [IDW-1:0]     res_id,
  output logic               busy
);
  localparam int SHW = clog2(W + 1);
  localparam int CW = (KEEP > 1) ? clog2(KEEP) : 1;
  localparam int AW = 2 * KEEP;
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, g;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [SHW-1:0] sha_q, sha_d, shb_q, shb_d, sha, shb;
  logic [KEEP-1:0] manta_q, manta_d, mantb_q, mantb_d, manta, mantb;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [2*W-1:0] res_q, res_d;
  logic [2*N_REQ-1:0] rot;
  logic found;
  int sum;
  approx_lod #(.W(W), .KEEP(KEEP), .SHW(SHW)) u_lod_a (.op_i(a_q), .sh_o(sha), .mant_o(manta));
  approx_lod #(.W(W), .KEEP(KEEP), .SHW(SHW)) u_lod_b (.op_i(b_q), .sh_o(shb), .mant_o(mantb));
  // Rotate the valid vector so bit 0 is the requester at the RR pointer
  always_comb begin
    found = 1'b0;
    g = '0;
    sum = 0;
    rot = {req_valid, req_valid} >> ptr_q;
    for (int o = 0; o < N_REQ; o++) begin
      if (!found && rot[o]) begin
        found = 1'b1;
        sum = int'(ptr_q) + o;
        g = IDW'((sum >= N_REQ) ? sum - N_REQ : sum);
      end
    end
  end
  assign req_ready = (state_q == IDLE && found) ? N_REQ'(1) << g : '0;
  assign res_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign res_data = res_q;
  assign res_id = id_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    sha_d = sha_q;
    shb_d = shb_q;
    manta_d = manta_q;
    mantb_d = mantb_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = NORM;
        ptr_d = (g == IDW'(N_REQ - 1)) ? '0 : g + 1'b1;
        id_d = g;
        a_d = req_a[int'(g)*W +: W];
        b_d = req_b[int'(g)*W +: W];
      end
      NORM: begin
        state_d = MUL;
        sha_d = sha;
        shb_d = shb;
        manta_d = manta;
        mantb_d = mantb;
        cnt_d = '0;
        acc_d = '0;
      end
      MUL: begin
        acc_d = acc_q + (mantb_q[cnt_q] ? AW'(manta_q) << cnt_q : '0);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(KEEP - 1)) begin
          state_d = DONE;
          res_d = (2*W)'(acc_d) << ({1'b0, sha_q} + {1'b0, shb_q});
        end
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sha_q <= '0;
      shb_q <= '0;
      manta_q <= '0;
      mantb_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      sha_q <= sha_d;
      shb_q <= shb_d;
      manta_q <= manta_d;
      mantb_q <= mantb_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_approx_mul_sched.sv
// tb_approx_mul_sched: table-driven and scoreboard checks of approx_mul_sched with N_REQ=2, KEEP=8
module tb_approx_mul_sched;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid;
  logic [31:0] req_a, req_b;
  logic [1:0] req_ready;
  logic res_valid, res_ready, busy;
  logic [31:0] res_data;
  logic [0:0] res_id;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gcyc = 0;
  typedef struct {
    int id;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    int id;
  } exp_t;
  exp_t sb[$];
  vec_t tv[10];

  approx_mul_sched #(.N_REQ(2), .KEEP(8), .W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic wait_grant(input string name, input logic [1:0] want);
    int k = 0;
    #1;
    while (req_ready == 2'b00 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 32'(req_ready), 32'(want));
    gcyc = cyc;
  endtask

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic start(input string name, input int id, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    exp_t e;
    set_op(id, a, b);
    wait_grant(name, 2'b01 << id);
    e.data = exp;
    e.id = id;
    sb.push_back(e);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic collect(input string name);
    int k = 0;
    exp_t e;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_lat"}, 32'(cyc - gcyc), 32'd10);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: got empty scoreboard expected pending entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, res_data, e.data);
      chk({name, "_id"}, 32'(res_id), 32'(e.id));
    end
  endtask

  initial begin
    exp_t e;
    tv[0] = '{0, 16'h00FF, 16'h0003, 32'h000002FD};
    tv[1] = '{1, 16'hFFFF, 16'hFFFF, 32'hFE010000};
    tv[2] = '{0, 16'h0000, 16'h1234, 32'h00000000};
    tv[3] = '{1, 16'h1234, 16'h0001, 32'h00001220};
    tv[4] = '{0, 16'h00AB, 16'h00CD, 32'h000088EF};
    tv[5] = '{1, 16'h8000, 16'h8000, 32'h40000000};
    tv[6] = '{0, 16'h0100, 16'h00FF, 32'h0000FF00};
    tv[7] = '{1, 16'h1234, 16'h5678, 32'h0616C000};
    tv[8] = '{0, 16'h0001, 16'h0001, 32'h00000001};
    tv[9] = '{1, 16'hFFFF, 16'h0000, 32'h00000000};
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_id", 32'(res_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    // Both requesters pending straight out of reset: 0 wins, 1 follows
    set_op(0, 16'h0010, 16'h0010);
    set_op(1, 16'h0020, 16'h0003);
    wait_grant("rr_first", 2'b01);
    e = '{32'h00000100, 0};
    sb.push_back(e);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("no_grant_busy", 32'(req_ready), 32'h0);
    chk("busy_norm", 32'(busy), 32'h1);
    collect("rr_a");
    @(negedge clk);
    wait_grant("rr_second", 2'b10);
    e = '{32'h00000060, 1};
    sb.push_back(e);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect("rr_b");
    @(negedge clk);
    start("rr_solo", 0, 16'h0003, 16'h0005, 32'h0000000F);
    collect("rr_c");
    @(negedge clk);
    set_op(0, 16'h0007, 16'h0007);
    set_op(1, 16'h0009, 16'h0009);
    wait_grant("rr_rotate", 2'b10);
    e = '{32'h00000051, 1};
    sb.push_back(e);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect("rr_d");
    @(negedge clk);
    wait_grant("rr_after", 2'b01);
    e = '{32'h00000031, 0};
    sb.push_back(e);
    @(negedge clk);
    req_valid[0] = 1'b0;
    collect("rr_e");
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start($sformatf("vec%0d_grant", i), tv[i].id, tv[i].a, tv[i].b, tv[i].exp);
      collect($sformatf("vec%0d", i));
      @(negedge clk);
    end
    // Backpressure: result must hold and no grant may issue until the handshake
    res_ready = 1'b0;
    start("bp_grant", 0, 16'h00FF, 16'h0003, 32'h000002FD);
    collect("bp");
    set_op(1, 16'h0002, 16'h0003);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_data", res_data, 32'h000002FD);
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", 32'(res_valid), 32'h0);
    wait_grant("bp_next", 2'b10);
    e = '{32'h00000006, 1};
    sb.push_back(e);
    @(negedge clk);
    req_valid[1] = 1'b0;
    collect("bp_next");
    @(negedge clk);
    // Reset landing on the third MUL cycle discards the operation
    start("ab_grant", 0, 16'h1234, 16'h5678, 32'h0616C000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_valid", 32'(res_valid), 32'h0);
    chk("ab_data", res_data, 32'h0);
    chk("ab_ready", 32'(req_ready), 32'h0);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    start("ab_post_grant", 0, 16'h00FF, 16'h0003, 32'h000002FD);
    collect("ab_post");
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
